// File: rtl/chip8_mem_arb.sv
// Shared CHIP-8 memory port: UART loader writes first, then fetch/draw reads with round-robin.
// Define CHIP8_ARB_LOCK_EN to add a draw burst lock (ST_LOCK) with a LOCK_MAX-cycle timeout.
module chip8_mem_arb #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int LOAD_BASE  = 512,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_i,
  input  logic                  rx_i_v,
  output logic [ADDR_WIDTH-1:0] load_addr,
  output logic                  load_full,
  output logic                  load_drop,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  input  logic                  draw_req,
  input  logic [ADDR_WIDTH-1:0] draw_addr,
  input  logic                  draw_lock,
  output logic                  draw_gnt,
  output logic                  draw_rvalid,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [DATA_WIDTH-1:0] mem_d
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  // The loader address parks on the top address instead of wrapping.
  function automatic logic [ADDR_WIDTH-1:0] sat_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_MAX) ? a : a + 1'b1;
  endfunction

  logic                  pend;
  logic [DATA_WIDTH-1:0] pend_byte;
  logic                  last_draw;
  logic                  closing;
  logic                  locked;
  logic                  timeout;
  logic                  re_p1;
  logic                  src_draw_p1;
  logic                  fetch_vld_p2;
  logic                  draw_vld_p2;

`ifdef CHIP8_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {ST_ARB, ST_LOCK} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] lock_cnt, cnt_nx;

  assign locked = (state == ST_LOCK) && draw_req && draw_lock;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ARB;
      lock_cnt <= '0;
    end else begin
      state    <= state_nx;
      lock_cnt <= cnt_nx;
    end
  end

  // The granting cycle in ST_ARB counts as the first locked cycle.
  always_comb begin
    state_nx = state;
    cnt_nx   = lock_cnt;
    timeout  = 1'b0;
    case (state)
      ST_ARB: begin
        if (draw_gnt && draw_lock) begin
          state_nx = ST_LOCK;
          cnt_nx   = CNT_W'(1);
        end
      end
      ST_LOCK: begin
        if (!locked) begin
          state_nx = ST_ARB;
          cnt_nx   = '0;
        end else if (lock_cnt >= CNT_W'(LOCK_MAX - 1)) begin
          state_nx = ST_ARB;
          cnt_nx   = '0;
          timeout  = 1'b1;
        end else begin
          cnt_nx = lock_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = ST_ARB;
        cnt_nx   = '0;
      end
    endcase
  end
`else
  logic unused_draw_lock;

  assign unused_draw_lock = draw_lock;
  assign locked           = 1'b0;
  assign timeout          = 1'b0;
`endif

  // p0: grant decision for this cycle; a pending byte always wins.
  always_comb begin
    fetch_gnt = 1'b0;
    draw_gnt  = 1'b0;
    if (!pend) begin
      if (locked) begin
        draw_gnt = 1'b1;
      end else if (fetch_req && draw_req) begin
        fetch_gnt = last_draw;
        draw_gnt  = !last_draw;
      end else begin
        fetch_gnt = fetch_req;
        draw_gnt  = draw_req;
      end
    end
  end

  // The byte arriving during the final write is ignored like any byte after it.
  assign closing = load_full || (pend && (load_addr == ADDR_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= 1'b0;
      load_addr <= ADDR_WIDTH'(LOAD_BASE);
      load_full <= 1'b0;
      load_drop <= 1'b0;
      last_draw <= 1'b0;
    end else begin
      if (pend) begin
        pend      <= 1'b0;
        load_addr <= sat_inc(load_addr);
        if (load_addr == ADDR_MAX) load_full <= 1'b1;
      end
      if (rx_i_v && !closing) begin
        if (pend) load_drop <= 1'b1;
        else      pend      <= 1'b1;
      end
      if (timeout)        last_draw <= 1'b1;
      else if (fetch_gnt) last_draw <= 1'b0;
      else if (draw_gnt)  last_draw <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_i_v && !pend) pend_byte <= rx_i;
  end

  // p1: registered memory strobes and addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we      <= 1'b0;
      re_p1       <= 1'b0;
      src_draw_p1 <= 1'b0;
      mem_waddr   <= '0;
      mem_raddr   <= '0;
      mem_d       <= '0;
    end else begin
      mem_we      <= pend;
      re_p1       <= fetch_gnt || draw_gnt;
      src_draw_p1 <= draw_gnt;
      if (pend) begin
        mem_waddr <= load_addr;
        mem_d     <= pend_byte;
      end
      if (fetch_gnt || draw_gnt) mem_raddr <= draw_gnt ? draw_addr : fetch_addr;
    end
  end

  // p2: read data valid at the memory output.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_vld_p2 <= 1'b0;
      draw_vld_p2  <= 1'b0;
    end else begin
      fetch_vld_p2 <= re_p1 && !src_draw_p1;
      draw_vld_p2  <= re_p1 && src_draw_p1;
    end
  end

  assign mem_re       = re_p1;
  assign fetch_rvalid = fetch_vld_p2;
  assign draw_rvalid  = draw_vld_p2;

endmodule

// File: doc/chip8_mem_arb.md
# chip8_mem_arb

Arbiter and sequencer for the single 4 KiB CHIP-8 program/sprite memory. It shares the memory port between three requesters:
- the UART program loader (write path, built into this block);
- the instruction fetch unit (read);
- the sprite draw engine (read).

It sits between the interpreter core and the `mem` instance, replacing the ad-hoc `state == ST_DRAW` read-address mux with a real request/grant protocol.

## Interface
- `ADDR_WIDTH`, 12, memory address width
- `DATA_WIDTH`, 8, memory data width
- `LOAD_BASE`, 512, first address written by the loader
- `LOCK_MAX`, 16, maximum consecutive cycles draw may hold a locked grant

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `rx_i`  in  8  received UART byte
- `rx_i_v`  in  1  `rx_i` valid strobe, one cycle
- `load_addr`  out  ADDR_WIDTH  next loader write address
- `load_full`  out  1  sticky: address 0xFFF written, loader closed
- `load_drop`  out  1  sticky: byte arrived while buffer occupied
- `fetch_req`  in  1  fetch read request
- `fetch_addr`  in  ADDR_WIDTH  fetch read address
- `fetch_gnt`  out  1  fetch granted this cycle (combinational)
- `fetch_rvalid`  out  1  `mem_q` holds fetch data
- `draw_req`  in  1  draw read request
- `draw_addr`  in  ADDR_WIDTH  draw read address
- `draw_lock`  in  1  request to keep the grant for a burst
- `draw_gnt`  out  1  draw granted this cycle (combinational)
- `draw_rvalid`  out  1  `mem_q` holds draw data
- `mem_we`, `mem_re`  out  1  memory write / read enables
- `mem_waddr`, `mem_raddr`  out  ADDR_WIDTH  memory addresses
- `mem_d`  out  DATA_WIDTH  memory write data

## Operation
- Loader:
  - `rx_i_v` captures `rx_i` into a 1-entry buffer and sets `pend`.
  - A pending byte always wins the next arbitration cycle (highest priority). The arbiter then writes it at `load_addr`, increments `load_addr`, and clears `pend`.
  - `rx_i_v` while `pend` is set: byte discarded, `load_drop` set.
  - After writing 0xFFF: `load_full` set, `load_addr` stays 0xFFF, further bytes are ignored. They do not set `load_drop`.
- Reads, when no write is pending:
  - If only one of fetch/draw requests, it wins.
  - If both request, round-robin: the requester not granted most recently wins. `last` resets to fetch, so draw wins the first tie.
  - A write cycle blocks both reads; losers keep `req` and `addr` asserted.
- States:
  - ST_ARB: normal arbitration. Goes to ST_LOCK when draw is granted with `draw_lock`=1.
  - ST_LOCK: draw wins whenever `draw_req`=1; fetch is blocked. A pending loader byte still preempts, and that cycle counts toward the lock limit. `lock_cnt` counts cycles in ST_LOCK.
  - ST_LOCK exits to ST_ARB on any of: `draw_lock`=0, `draw_req`=0, or `lock_cnt`=LOCK_MAX-1.
  - On timeout: `last` is forced to draw, so a waiting fetch wins the next tie.
- `gnt` is a one-cycle pulse per access. A requester holding `req` high across cycles gets one access per cycle it wins.
- Reset: state ST_ARB, `pend`=0, `load_addr`=LOAD_BASE, `load_full`=0, `load_drop`=0, `lock_cnt`=0, `last`=fetch. All outputs are 0 except `load_addr`.

## Timing
- Cycle N: the `gnt` output goes high combinationally from `req`/`pend`. The arbiter samples the address at the end of N.
- Cycle N+1: registered `mem_re`/`mem_raddr`, or registered `mem_we`/`mem_waddr`/`mem_d`.
- Cycle N+2: the matching `rvalid` is high and `mem_q` is valid. Read latency is 2 cycles from grant.
- Requesters may change `addr`, or drop `req`, in N+1.
- Write from `rx_i_v`: the byte is captured at edge N; `mem_we` is high in N+2 when uncontended.
- `rst` mid-access: the memory strobes that are in flight are suppressed from the next edge, the pending byte is lost, and `rvalid` goes low.

## Configuration
- `CHIP8_ARB_LOCK_EN` defined: ST_LOCK, `lock_cnt` and the timeout are compiled in, as described above.
- `CHIP8_ARB_LOCK_EN` undefined: `draw_lock` is ignored and there is no ST_LOCK. The arbiter is pure loader-first plus round-robin.

## Test plan
- Reset, then `rx_i`=0x6A, 0x0C on separate strobes: `mem_we` at addresses 0x200 then 0x201 with data 0x6A, 0x0C; `load_addr`=0x202.
- `fetch_req` and `draw_req` held together for 4 cycles: grants alternate draw, fetch, draw, fetch. `rvalid` follows each grant by 2 cycles.
- Byte pending while fetch requests: the write is granted first, then `fetch_gnt` comes one cycle later.
- Lock enabled, LOCK_MAX=16, draw locked with `fetch_req` held: 16 consecutive `draw_gnt`, then `fetch_gnt` on cycle 17.
- Two `rx_i_v` strobes in adjacent cycles while a write is pending: the second byte is dropped and `load_drop`=1.
- `load_addr`=0xFFF, two bytes sent: one write at 0xFFF, `load_full`=1, no second `mem_we`. Assert `rst` mid-read: no `rvalid` on the following cycle.
